// File: rtl/serial_fa_sequencer.sv
// Bit-serial adder sequencer: feeds an external combinational full adder one
// operand bit pair per clock (LSB first) and collects the sum into a result register.
module serial_fa_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only in IDLE. An accepted start captures a/b/cin,
  // and busy then stays high through SHIFT and DONE. done is a single-cycle pulse
  // in DONE. sum/cout/ovf are valid from that pulse until the next completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] s_next;

  assign dbg_state = state;
  assign fa_a      = (state == SHIFT) & a_sr[0];
  assign fa_b      = (state == SHIFT) & b_sr[0];
  assign fa_cin    = (state == SHIFT) & carry;

  // Earlier sum bits are kept in WIDTH-1 flops; the current fa_sum completes the word.
  generate
    if (WIDTH == 1) begin : g_one
      assign s_next = fa_sum;
    end else begin : g_multi
      logic [WIDTH-2:0] s_sr;
      assign s_next = {fa_sum, s_sr};
      always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
          s_sr <= '0;
        end else if (state == SHIFT) begin
          s_sr <= s_next[WIDTH-1:1];
        end
      end
    end
  endgenerate

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_cout;
          if (cnt == LAST) begin
            // carry holds the carry into the MSB during the last bit
            sum   <= s_next;
            cout  <= fa_cout;
            ovf   <= carry ^ fa_cout;
            cnt   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_fa_sequencer.sv
// Directed bench for serial_fa_sequencer: an 8-bit and a 1-bit instance, each
// closed through a behavioural full adder.
module tb_serial_fa_sequencer;

  logic       CK;
  logic       RST;

  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       fa_a;
  logic       fa_b;
  logic       fa_cin;
  logic       fa_sum;
  logic       fa_cout;
  logic [1:0] dbg_state;

  logic       start1;
  logic       a1;
  logic       b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic       sum1;
  logic       cout1;
  logic       ovf1;
  logic       fa_a1;
  logic       fa_b1;
  logic       fa_cin1;
  logic       fa_sum1;
  logic       fa_cout1;
  logic [1:0] dbg_state1;

  int checks;
  int failures;
  logic [9:0] exp_q[$];

  assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout  = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
  assign fa_sum1  = fa_a1 ^ fa_b1 ^ fa_cin1;
  assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

  serial_fa_sequencer #(.WIDTH(8)) u_w8 (
    .CK(CK), .RST(RST), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
    .fa_sum(fa_sum), .fa_cout(fa_cout), .dbg_state(dbg_state)
  );

  serial_fa_sequencer #(.WIDTH(1)) u_w1 (
    .CK(CK), .RST(RST), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1),
    .fa_sum(fa_sum1), .fa_cout(fa_cout1), .dbg_state(dbg_state1)
  );

  // clock / reset
  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: one 8-bit addition, returns latency in edges and the fa_a bit sequence
  task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         output int lat, output logic [7:0] seq);
    @(negedge CK);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    lat = -1;
    seq = '0;
    for (int n = 0; n < 40; n++) begin
      if (n < 8) seq[n] = fa_a;
      @(posedge CK); #1;
      if (done) begin
        lat = n + 1;
        break;
      end
    end
  endtask

  task automatic finish_add();
    @(posedge CK); #1;
  endtask

  task automatic run_add1(input logic ta, input logic tb_v, input logic tc, output int lat);
    @(negedge CK);
    a1 = ta; b1 = tb_v; cin1 = tc; start1 = 1'b1;
    @(posedge CK); #1;
    start1 = 1'b0;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(posedge CK); #1;
      if (done1) begin
        lat = n + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CK);
    #1;
    checks++;
    if ({busy, done, cout, ovf} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {busy, done, cout, ovf});
    end
    checks++;
    if (sum !== 8'h00) begin
      failures++;
      $display("FAIL reset_sum got=%h exp=00", sum);
    end
    checks++;
    if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
      failures++;
      $display("FAIL reset_fa got=%b exp=000", {fa_a, fa_b, fa_cin});
    end
    checks++;
    if (dbg_state !== 2'd0 || dbg_state1 !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d/%0d exp=0/0", dbg_state, dbg_state1);
    end
    @(negedge CK);
    RST = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    logic [7:0] seq;
    run_add(8'h5A, 8'h3C, 1'b0, lat, seq);
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=8", lat);
    end
    checks++;
    if ({sum, cout, ovf} !== {8'h96, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL basic_result got=%h/%b/%b exp=96/0/1", sum, cout, ovf);
    end
    checks++;
    if (seq !== 8'h5A) begin
      failures++;
      $display("FAIL basic_fa_a_seq got=%b exp=01011010", seq);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy_in_done got=%b exp=1", busy);
    end
    finish_add();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL basic_after_done got=%b exp=00", {busy, done});
    end
  endtask

  task automatic test_carry_cases();
    logic [7:0] ta [4] = '{8'hFF, 8'hFF, 8'h7F, 8'h80};
    logic [7:0] tbv[4] = '{8'h01, 8'h00, 8'h00, 8'h80};
    logic       tc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [9:0] ex [4] = '{{8'h00, 1'b1, 1'b0}, {8'h00, 1'b1, 1'b0},
                           {8'h80, 1'b0, 1'b1}, {8'h00, 1'b1, 1'b1}};
    int lat;
    logic [7:0] seq;
    for (int i = 0; i < 4; i++) begin
      run_add(ta[i], tbv[i], tc[i], lat, seq);
      checks++;
      if (lat !== 8 || {sum, cout, ovf} !== ex[i]) begin
        failures++;
        $display("FAIL carry_case%0d got=lat%0d %h/%b/%b exp=lat8 %h/%b/%b", i, lat,
                 sum, cout, ovf, ex[i][9:2], ex[i][1], ex[i][0]);
      end
      finish_add();
    end
  endtask

  // start held high with fresh operands every cycle; accepted only from IDLE,
  // so acceptances fall at cycles 0, 10, 20, 30 (8 SHIFT + DONE + one IDLE)
  task automatic test_back_to_back();
    int done_at[$];
    int exp_at[4] = '{8, 18, 28, 38};
    logic [9:0] got;
    exp_q.push_back({8'h04, 1'b0, 1'b0});
    exp_q.push_back({8'hE1, 1'b0, 1'b0});
    exp_q.push_back({8'hBC, 1'b0, 1'b1});
    exp_q.push_back({8'h99, 1'b0, 1'b0});
    for (int c = 0; c < 45; c++) begin
      @(negedge CK);
      a = 8'(c * 17 + 3);
      b = 8'(c * 5 + 1);
      cin = c[1];
      start = (c <= 30);
      @(posedge CK); #1;
      if (done) begin
        done_at.push_back(c);
        got = {sum, cout, ovf};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected_done got=cycle%0d exp=none", c);
        end else if (got !== exp_q[0]) begin
          failures++;
          $display("FAIL b2b_result got=%h/%b/%b exp=%h/%b/%b", sum, cout, ovf,
                   exp_q[0][9:2], exp_q[0][1], exp_q[0][0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
    start = 1'b0;
    checks++;
    if (done_at.size() != 4) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d exp=4", done_at.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (done_at[i] != exp_at[i]) begin
          failures++;
          $display("FAIL b2b_done_cycle%0d got=%0d exp=%0d", i, done_at[i], exp_at[i]);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [7:0] seq;
    @(negedge CK);
    a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    repeat (4) @(posedge CK);
    #1;
    checks++;
    if ({busy, fa_a, fa_b} !== 3'b111) begin
      failures++;
      $display("FAIL midrst_bit4_inputs got=%b exp=111", {busy, fa_a, fa_b});
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({busy, done, cout, ovf, fa_a, fa_b, fa_cin} !== 7'b0) begin
      failures++;
      $display("FAIL midrst_async_flags got=%b exp=0000000",
               {busy, done, cout, ovf, fa_a, fa_b, fa_cin});
    end
    checks++;
    if (sum !== 8'h00) begin
      failures++;
      $display("FAIL midrst_async_sum got=%h exp=00", sum);
    end
    @(negedge CK);
    RST = 1'b0;
    run_add(8'h01, 8'h02, 1'b0, lat, seq);
    checks++;
    if (lat !== 8 || {sum, cout, ovf} !== {8'h03, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midrst_restart got=lat%0d %h/%b/%b exp=lat8 03/0/0", lat, sum, cout, ovf);
    end
    finish_add();
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 20; i++) begin
      @(negedge CK);
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      @(posedge CK); #1;
      checks++;
      if ({sum, cout, ovf} !== {8'h03, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL idle_result cyc%0d got=%h/%b/%b exp=03/0/0", i, sum, cout, ovf);
      end
      checks++;
      if ({fa_a, fa_b, fa_cin, busy, done} !== 5'b0) begin
        failures++;
        $display("FAIL idle_outputs cyc%0d got=%b exp=00000", i,
                 {fa_a, fa_b, fa_cin, busy, done});
      end
    end
  endtask

  task automatic test_width1();
    logic [2:0] op[3] = '{3'b111, 3'b100, 3'b001};
    logic [2:0] ex[3] = '{3'b110, 3'b100, 3'b101};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_add1(op[i][2], op[i][1], op[i][0], lat);
      checks++;
      if (lat !== 1 || {sum1, cout1, ovf1} !== ex[i]) begin
        failures++;
        $display("FAIL w1_case%0d got=lat%0d %b exp=lat1 %b", i, lat,
                 {sum1, cout1, ovf1}, ex[i]);
      end
      @(posedge CK); #1;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    RST = 1'b1;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    test_reset();
    test_basic();
    test_carry_cases();
    test_back_to_back();
    test_reset_mid();
    test_idle_hold();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
